fir_shift_pipe: RTL and testbench

Parametrised shift-and-add FIR filter. It is the streaming successor of the fixed 5-tap shift FIR.
- Adds a registered input stage, a valid-qualified delay line and a runtime-programmable per-tap shift/enable bank.
- Adds a fill tracker, synchronous clear and an optional output saturation mode.
- Sits between a sample source and the downstream datapath; coefficients are written by a control block.

---
 rtl/fir_shift_pipe.sv | 108 ++++++++++
 tb/tb_fir_shift_pipe.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/fir_shift_pipe.sv
// fir_shift_pipe: streaming shift-and-add FIR with valid-qualified delay line,
// runtime-programmable per-tap {enable, shift} bank, fill tracker and clr.
// Optional build macro FIR_SHIFT_PIPE_SATURATE_EN: clamp oversize sums to the
// output maximum instead of keeping the low OUT_W bits.

module fir_shift_pipe #(
   parameter int unsigned NTAPS  = 5,
   parameter int unsigned DATA_W = 8,
   parameter int unsigned OUT_W  = 10,
   parameter int unsigned SH_W   = 3,
   parameter int unsigned ADDR_W = 3
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              in_valid,
   input  logic [DATA_W-1:0] x,
   input  logic              clr,
   input  logic              cfg_we,
   input  logic [ADDR_W-1:0] cfg_addr,
   input  logic [SH_W:0]     cfg_data,
   output logic [OUT_W-1:0]  dataout,
   output logic              out_valid,
   output logic              primed
);

   // Full-precision sum width; widened to OUT_W when the output is the larger
   localparam int unsigned SUM_W  = DATA_W + $clog2(NTAPS);
   localparam int unsigned EXT_W  = (SUM_W > OUT_W) ? SUM_W : OUT_W;
   localparam int unsigned CNT_W  = $clog2(NTAPS + 1);
   localparam int unsigned SH_MOD = 1 << SH_W;

   logic [DATA_W-1:0] d    [NTAPS];
   logic [SH_W:0]     coef [NTAPS];
   logic              vld_q;
   logic [CNT_W-1:0]  fill_cnt;
   logic [EXT_W-1:0]  sum_c;
   logic [OUT_W-1:0]  out_c;

   // Delay line: shifts only on accepted samples, so in_valid gaps insert nothing
   always_ff @(posedge clk) begin
      if (rst || clr) begin
         for (int k = 0; k < int'(NTAPS); k++) d[k] <= '0;
      end else if (in_valid) begin
         d[0] <= x;
         for (int k = 1; k < int'(NTAPS); k++) d[k] <= d[k-1];
      end
   end

   // Coefficient bank: reset defaults {1, NTAPS-k}; out-of-range writes ignored
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int k = 0; k < int'(NTAPS); k++)
            coef[k] <= {1'b1, SH_W'((NTAPS - k) % SH_MOD)};
      end else if (cfg_we) begin
         for (int k = 0; k < int'(NTAPS); k++)
            if (cfg_addr == ADDR_W'(k)) coef[k] <= cfg_data;
      end
   end

   // Shift-and-add over the current line at full width
   always_comb begin
      sum_c = '0;
      for (int k = 0; k < int'(NTAPS); k++) begin
         if (coef[k][SH_W])
            sum_c = sum_c + EXT_W'(d[k] >> coef[k][SH_W-1:0]);
      end
   end

`ifdef FIR_SHIFT_PIPE_SATURATE_EN
   localparam logic [EXT_W-1:0] OUT_MAX = EXT_W'((64'd1 << OUT_W) - 64'd1);

   // Width reduction: clamp to the largest representable output
   always_comb begin
      out_c = OUT_W'(sum_c);
      if (sum_c > OUT_MAX) out_c = '1;
   end
`else
   // Width reduction: keep the low OUT_W bits (wrap)
   always_comb begin
      out_c = OUT_W'(sum_c);
   end
`endif

   // Output stage, valid pipeline and fill tracking; clr keeps dataout
   always_ff @(posedge clk) begin
      if (rst) begin
         vld_q     <= 1'b0;
         fill_cnt  <= '0;
         out_valid <= 1'b0;
         primed    <= 1'b0;
         dataout   <= '0;
      end else if (clr) begin
         vld_q     <= 1'b0;
         fill_cnt  <= '0;
         out_valid <= 1'b0;
         primed    <= 1'b0;
      end else begin
         vld_q     <= in_valid;
         out_valid <= vld_q;
         primed    <= (fill_cnt == CNT_W'(NTAPS));
         if (in_valid && (fill_cnt != CNT_W'(NTAPS)))
            fill_cnt <= fill_cnt + CNT_W'(1);
         if (vld_q)
            dataout <= out_c;
      end
   end

endmodule

// File: tb/tb_fir_shift_pipe.sv
// tb_fir_shift_pipe: directed bench for fir_shift_pipe with default parameters.

module tb_fir_shift_pipe;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       in_valid = 1'b0;
   logic [7:0] x = '0;
   logic       clr = 1'b0;
   logic       cfg_we = 1'b0;
   logic [2:0] cfg_addr = '0;
   logic [3:0] cfg_data = '0;
   logic [9:0] dataout;
   logic       out_valid;
   logic       primed;

   int nchecks = 0;
   int nerrors = 0;

   int ramp [5]    = '{7, 22, 53, 116, 243};
   int impulse [6] = '{4, 8, 16, 32, 64, 0};
   int tap2off [5] = '{7, 22, 22, 85, 212};
   int exp_big;

   fir_shift_pipe dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .x         (x),
      .clr       (clr),
      .cfg_we    (cfg_we),
      .cfg_addr  (cfg_addr),
      .cfg_data  (cfg_data),
      .dataout   (dataout),
      .out_valid (out_valid),
      .primed    (primed)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input int obs, input int expv);
      nchecks++;
      assert (obs === expv) else begin
         nerrors++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
      end
   endtask

   task automatic cfg_write(input int addr, input int data);
      cfg_we   = 1'b1;
      cfg_addr = 3'(addr);
      cfg_data = 4'(data);
      tick();
      cfg_we   = 1'b0;
   endtask

   // Stream n samples of x=255 back to back from an empty line; check ramp
   task automatic ramp_check(input string tag, input int n);
      in_valid = 1'b1;
      x = 8'd255;
      tick();
      chk({tag, "_lat"}, int'(out_valid), 0);
      for (int i = 0; i < n; i++) begin
         if (i == n - 1) in_valid = 1'b0;
         tick();
         chk({tag, "_ov"}, int'(out_valid), 1);
         chk({tag, "_dout"}, int'(dataout), (i < 5) ? ramp[i] : 243);
         chk({tag, "_primed"}, int'(primed), (i >= 4) ? 1 : 0);
      end
      tick();
      chk({tag, "_ov_end"}, int'(out_valid), 0);
      chk({tag, "_hold"}, int'(dataout), 243);
   endtask

   initial begin
`ifdef FIR_SHIFT_PIPE_SATURATE_EN
      exp_big = 1023;
`else
      exp_big = 251;
`endif
      // Reset state
      tick();
      tick();
      rst = 1'b0;
      chk("rst_dout", int'(dataout), 0);
      chk("rst_ov", int'(out_valid), 0);
      chk("rst_primed", int'(primed), 0);

      // 1: constant 255 stream
      ramp_check("t1", 8);

      // 2: impulse response
      clr = 1'b1;
      tick();
      clr = 1'b0;
      chk("t2_clr_primed", int'(primed), 0);
      chk("t2_clr_dout_kept", int'(dataout), 243);
      in_valid = 1'b1;
      x = 8'd128;
      tick();
      x = 8'd0;
      for (int i = 0; i < 6; i++) begin
         tick();
         chk("t2_ov", int'(out_valid), 1);
         chk("t2_dout", int'(dataout), impulse[i]);
      end
      in_valid = 1'b0;
      tick();
      tick();

      // 3: in_valid toggling, no zero insertion
      clr = 1'b1;
      tick();
      clr = 1'b0;
      x = 8'd255;
      for (int i = 0; i < 12; i++) begin
         in_valid = (i < 10) && (i % 2 == 0);
         tick();
         if (i >= 1 && ((i - 1) % 2 == 0) && (i - 1) < 10) begin
            chk("t3_ov", int'(out_valid), 1);
            chk("t3_dout", int'(dataout), ramp[(i - 1) / 2]);
            chk("t3_primed", int'(primed), ((i - 1) / 2 == 4) ? 1 : 0);
         end else begin
            chk("t3_ov_gap", int'(out_valid), 0);
         end
      end
      in_valid = 1'b0;

      // 4: all taps {1,0}; line already holds 255s
      for (int k = 0; k < 5; k++) cfg_write(k, 8);
      in_valid = 1'b1;
      x = 8'd255;
      tick();
      in_valid = 1'b0;
      tick();
      chk("t4_ov", int'(out_valid), 1);
      chk("t4_dout", int'(dataout), exp_big);

      // 5: tap 2 disabled, tap 7 write ignored (issued alongside a sample)
      rst = 1'b1;
      tick();
      rst = 1'b0;
      cfg_write(2, 4'b0011);
      in_valid = 1'b1;
      x = 8'd255;
      cfg_we = 1'b1;
      cfg_addr = 3'd7;
      cfg_data = 4'b1000;
      tick();
      cfg_we = 1'b0;
      for (int i = 0; i < 6; i++) begin
         if (i == 5) in_valid = 1'b0;
         tick();
         chk("t5_ov", int'(out_valid), 1);
         chk("t5_dout", int'(dataout), (i < 5) ? tap2off[i] : 212);
      end
      tick();

      // 6a: clr with in_valid mid-stream
      rst = 1'b1;
      tick();
      rst = 1'b0;
      in_valid = 1'b1;
      x = 8'd255;
      tick();
      tick();
      chk("t6_pre0", int'(dataout), 7);
      tick();
      chk("t6_pre1", int'(dataout), 22);
      clr = 1'b1;
      tick();
      clr = 1'b0;
      in_valid = 1'b0;
      chk("t6_clr_ov", int'(out_valid), 0);
      chk("t6_clr_primed", int'(primed), 0);
      chk("t6_clr_dout", int'(dataout), 22);
      tick();
      chk("t6_clr_ov2", int'(out_valid), 0);
      ramp_check("t6", 5);

      // 6b: rst mid-stream restores default coefficients
      for (int k = 0; k < 5; k++) cfg_write(k, 8);
      in_valid = 1'b1;
      x = 8'd255;
      tick();
      tick();
      rst = 1'b1;
      tick();
      rst = 1'b0;
      in_valid = 1'b0;
      chk("t6r_ov", int'(out_valid), 0);
      chk("t6r_dout", int'(dataout), 0);
      chk("t6r_primed", int'(primed), 0);
      tick();
      chk("t6r_ov2", int'(out_valid), 0);
      ramp_check("t6r", 5);

      $display("Simulation finished: %0d checks, %0d errors", nchecks, nerrors);
      $finish;
   end

endmodule
